seven_seg_display: RTL
======================

Name: seven_seg_display

Overview:
- Instruction-driven 4-digit multiplexed seven-segment display peripheral.
- Sits downstream of the sequencer, alongside the LED bank and push-button peripherals.
- Consumes the shared 12-bit output-register instruction word when its own enable bit is asserted.
- Holds four hex digits and a per-digit blank mask; scans digits at a programmable rate and drives active-low segment and anode pins.

Parameters:
- ScanWait, 50000: clock cycles each digit stays lit before the scan advances. Must be ≥ 1.
- ScanSize, 16: width of the scan prescaler counter. Must hold ScanWait-1.

Ports:
- clock  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- inst  in  12  instruction word: inst[11:8] opcode, inst[7:0] immediate.
- inst_en  in  1  instruction valid this cycle.
- segments  out  7  active-low segments, bit0=a … bit6=g.
- anodes  out  4  active-low digit enables, bit0 = rightmost digit.

Behaviour:
- Reset (reset=0, asynchronous):
  - digits=16'h0000, mask=4'hF (all blank), scan index=0, prescaler=0, state=Ready.
  - segments=7'h7F, anodes=4'hF.
- States:
  - Ready: accepts instructions.
  - Error: sticky; left only by reset.
- Opcodes, decoded only when inst_en=1 and state=Ready:
  - 0 NOP: no change.
  - 1 LDL: digits[7:0] ← imm (digit1 = imm[7:4], digit0 = imm[3:0]).
  - 2 LDH: digits[15:8] ← imm.
  - 3 LDM: mask ← imm[3:0]; imm[7:4] ignored. A mask bit of 1 blanks that digit.
  - Any other opcode (4–15 without the optional feature) → Error. No register change on that cycle.
- inst_en=0: inst is ignored entirely.
- Register write latency: the new value is visible in internal state one cycle after the inst_en cycle.
- Scan:
  - Prescaler increments every cycle in Ready.
  - When prescaler = ScanWait-1: prescaler → 0 and index → (index+1) mod 4 (order 0,1,2,3,0…).
  - Prescaler and index keep running while instructions are accepted.
- Output stage, registered, one cycle after the index or data change:
  - anodes = ~(1<<index) when mask[index]=0, else 4'hF.
  - segments = decode(digits[4*index+3 : 4*index]) when the digit is shown, else 7'h7F.
- Error state: anodes=4'hF, segments=7'h7F. Prescaler frozen. Further inst_en ignored.
- Simultaneous events:
  - An instruction on the same cycle as a scan wrap: both take effect.
  - The displayed digit uses the post-write value one cycle later.
- Reset asserted mid-scan or in Error: immediate return to the reset values above. Operation resumes on the first clock edge after reset deasserts.
- Decode table (active-low g..a):
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E

Optional Feature:
- Macro: SEVEN_SEG_DISPLAY_DP_EN.
- Defined:
  - Adds output port dp (1 bit, active-low, reset 1) and a 4-bit dp register (reset 0).
  - Opcode 4 LDP: dp register ← imm[3:0].
  - dp = ~dpreg[index] when the digit is shown, else 1. Registered with segments.
- Undefined: no dp port, no dp register; opcode 4 → Error.

Decomposition:
- Shared package contents:
  - Opcode constants (NOP=0, LDL=1, LDH=2, LDM=3, LDP=4).
  - State encoding (Ready, Error).
  - Inst field widths (opcode 4, immediate 8).
  - Blank segment constant 7'h7F.
- One sub-module, seven_seg_decode: combinational 4-bit hex to 7-bit active-low segments, instantiated once on the muxed digit.

Test Plan:
- Reset, then idle 20 cycles with ScanWait=4 → anodes=4'hF, segments=7'h7F throughout.
- LDL 8'h21, LDH 8'h43, LDM 8'h00, ScanWait=4 → anodes cycle E,D,B,7, each held 4 cycles, with segments 40? no: 79, 24, 30, 19 for digits 1, 2, 3, 4.
- LDM 8'h05 after the previous load → anodes show only D and 7 at index 1 and 3; at index 0 and 2 anodes=F, segments=7F.
- Opcode 7 with inst_en=1 → Error next cycle; outputs F/7F; a subsequent LDL 8'hFF does not change digits (checked after reset deasserts without reload: digits=0000).
- inst=LDL 8'h88 with inst_en=0 → no change; assert reset mid-scan at index 2 → anodes=F immediately (asynchronous), index 0 after release.
- With SEVEN_SEG_DISPLAY_DP_EN: LDP 8'h01, mask 0 → dp=0 only while anodes=E; without the macro, opcode 4 → Error.

Source files
------------

// File: rtl/seven_seg_display_pkg.sv
// Shared definitions for the seven-segment display peripheral: instruction
// layout, opcodes, controller states and the blank segment pattern.
package seven_seg_display_pkg;

  localparam int OPCODE_W = 4;
  localparam int IMM_W    = 8;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [IMM_W-1:0]    imm;
  } inst_t;

  localparam logic [OPCODE_W-1:0] OP_NOP = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_LDL = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_LDH = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_LDM = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_LDP = 4'd4;

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_ERROR = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_seg_display_decode.sv
// Combinational hex digit to active-low segment pattern (bit0=a .. bit6=g).
module seven_seg_decode
  import seven_seg_display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Hex glyph lookup
  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0:    seg_o = 7'h40;
      4'h1:    seg_o = 7'h79;
      4'h2:    seg_o = 7'h24;
      4'h3:    seg_o = 7'h30;
      4'h4:    seg_o = 7'h19;
      4'h5:    seg_o = 7'h12;
      4'h6:    seg_o = 7'h02;
      4'h7:    seg_o = 7'h78;
      4'h8:    seg_o = 7'h00;
      4'h9:    seg_o = 7'h10;
      4'hA:    seg_o = 7'h08;
      4'hB:    seg_o = 7'h03;
      4'hC:    seg_o = 7'h46;
      4'hD:    seg_o = 7'h21;
      4'hE:    seg_o = 7'h06;
      4'hF:    seg_o = 7'h0E;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_display.sv
// Instruction-driven 4-digit multiplexed seven-segment display with sticky error.
// Optional decimal-point support is enabled with SEVEN_SEG_DISPLAY_DP_EN.
module seven_seg_display
  import seven_seg_display_pkg::*;
#(
  parameter int ScanWait = 50000,
  parameter int ScanSize = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  output logic [6:0]  segments,
  output logic [3:0]  anodes
`ifdef SEVEN_SEG_DISPLAY_DP_EN
  ,
  output logic        dp
`endif
);

  localparam logic [ScanSize-1:0] PRESC_LAST = ScanSize'(ScanWait - 1);
  localparam logic [ScanSize-1:0] PRESC_ONE  = ScanSize'(1);

  inst_t                inst_s;
  state_e               state_q, state_d;
  logic [15:0]          digits_q;
  logic [3:0]           mask_q;
  logic [1:0]           idx_q;
  logic [ScanSize-1:0]  presc_q;
  logic                 wr_lo_s, wr_hi_s, wr_mask_s, wr_dp_s, bad_op_s;
  logic                 advance_s;
  logic [3:0]           digit_s;
  logic [6:0]           glyph_s;
  logic                 shown_s;
  logic [6:0]           seg_d, seg_q;
  logic [3:0]           an_d, an_q;

  assign inst_s = inst;

  // Instruction decode into per-register write strobes
  always_comb begin
    wr_lo_s   = 1'b0;
    wr_hi_s   = 1'b0;
    wr_mask_s = 1'b0;
    wr_dp_s   = 1'b0;
    bad_op_s  = 1'b0;
    if (inst_en && (state_q == ST_READY)) begin
      case (inst_s.opcode)
        OP_NOP:  bad_op_s  = 1'b0;
        OP_LDL:  wr_lo_s   = 1'b1;
        OP_LDH:  wr_hi_s   = 1'b1;
        OP_LDM:  wr_mask_s = 1'b1;
`ifdef SEVEN_SEG_DISPLAY_DP_EN
        OP_LDP:  wr_dp_s   = 1'b1;
`endif
        default: bad_op_s  = 1'b1;
      endcase
    end else begin
      bad_op_s = 1'b0;
    end
  end

  // Next-state logic: an illegal opcode locks the controller in Error
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READY: begin
        if (bad_op_s) begin
          state_d = ST_ERROR;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  // Controller state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_READY;
    end else begin
      state_q <= state_d;
    end
  end

  // The error-trigger cycle also freezes the scan, leaving every register untouched
  assign advance_s = (state_q == ST_READY) && !bad_op_s;

  // Digit, mask and scan registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digits_q <= 16'h0000;
      mask_q   <= 4'hF;
      idx_q    <= 2'd0;
      presc_q  <= '0;
    end else begin
      if (wr_lo_s) begin
        digits_q[7:0] <= inst_s.imm;
      end
      if (wr_hi_s) begin
        digits_q[15:8] <= inst_s.imm;
      end
      if (wr_mask_s) begin
        mask_q <= inst_s.imm[3:0];
      end
      if (advance_s) begin
        if (presc_q == PRESC_LAST) begin
          presc_q <= '0;
          idx_q   <= idx_q + 2'd1;
        end else begin
          presc_q <= presc_q + PRESC_ONE;
        end
      end
    end
  end

  assign digit_s = digits_q[{idx_q, 2'b00} +: 4];
  assign shown_s = (state_q == ST_READY) && !mask_q[idx_q];

  seven_seg_decode u_decode (
    .hex_i (digit_s),
    .seg_o (glyph_s)
  );

  // Output stage values for the currently scanned digit
  always_comb begin
    if (shown_s) begin
      seg_d = glyph_s;
      an_d  = ~(4'b0001 << idx_q);
    end else begin
      seg_d = SEG_BLANK;
      an_d  = 4'hF;
    end
  end

  // Registered pin drivers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign segments = seg_q;
  assign anodes   = an_q;

`ifdef SEVEN_SEG_DISPLAY_DP_EN
  logic [3:0] dpreg_q;
  logic       dp_d, dp_q;

  // Decimal-point register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dpreg_q <= 4'h0;
    end else if (wr_dp_s) begin
      dpreg_q <= inst_s.imm[3:0];
    end else begin
      dpreg_q <= dpreg_q;
    end
  end

  // Decimal-point pin value, blanked with its digit
  always_comb begin
    if (shown_s) begin
      dp_d = ~dpreg_q[idx_q];
    end else begin
      dp_d = 1'b1;
    end
  end

  // Registered decimal-point pin
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dp_q <= 1'b1;
    end else begin
      dp_q <= dp_d;
    end
  end

  assign dp = dp_q;
`else
  logic unused_dp_s;
  assign unused_dp_s = wr_dp_s;
`endif

endmodule
